// File: rtl/fc_sequencer.sv
// fc_sequencer: time-multiplexed fully-connected layer using one shared signed MAC
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   in_valid_i / in_ready_o    input vector handshake; in_data_i holds INPUT_SIZE elements,
//                              in_bias_i holds OUTPUT_SIZE biases, element k at [(k+1)*BITWIDTH-1 -: BITWIDTH]
//   w_en_o, w_addr_o           weight memory read port, address o*INPUT_SIZE+j
//   w_rdata_i                  weight data, one cycle after w_en_o
//   out_valid_o / out_ready_i  result handshake; out_data_o, out_index_o, out_last_o held until accepted
//   busy_o                     high whenever not idle
module fc_sequencer #(
    parameter int BITWIDTH    = 8,
    parameter int INPUT_SIZE  = 7,
    parameter int OUTPUT_SIZE = 5,
    parameter int WADDR_W     = $clog2(INPUT_SIZE * OUTPUT_SIZE),
    parameter int OIW         = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [BITWIDTH*INPUT_SIZE-1:0]  in_data_i,
    input  logic [BITWIDTH*OUTPUT_SIZE-1:0] in_bias_i,
    output logic                            w_en_o,
    output logic [WADDR_W-1:0]              w_addr_o,
    input  logic [BITWIDTH-1:0]             w_rdata_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [2*BITWIDTH-1:0]           out_data_o,
    output logic [OIW-1:0]                  out_index_o,
    output logic                            out_last_o,
    output logic                            busy_o
);
    localparam int JW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, MAC, BIAS, OUT} state_t;

    state_t                          state_q, state_d;
    logic [OIW-1:0]                  o_q, o_d;
    logic [JW-1:0]                   j_q, j_d, idx_q;
    logic                            v_q;
    logic [2*BITWIDTH-1:0]           acc_q, acc_d, out_q, out_d, prod, bias_x;
    logic [BITWIDTH*INPUT_SIZE-1:0]  data_q, data_d;
    logic [BITWIDTH*OUTPUT_SIZE-1:0] bias_q, bias_d;
    logic [BITWIDTH-1:0]             x, b;

    // Weight data lags the address by one cycle, so the operand index is the delayed j.
    assign x      = data_q[idx_q*BITWIDTH +: BITWIDTH];
    assign b      = bias_q[o_q*BITWIDTH +: BITWIDTH];
    // Sign-extended operands multiplied at full width: the low 2*BITWIDTH bits equal the signed product.
    assign prod   = v_q ? {{BITWIDTH{x[BITWIDTH-1]}}, x} * {{BITWIDTH{w_rdata_i[BITWIDTH-1]}}, w_rdata_i} : '0;
    assign bias_x = {{BITWIDTH{b[BITWIDTH-1]}}, b};

    assign in_ready_o  = rst_ni && state_q == IDLE;
    assign w_en_o      = state_q == MAC;
    assign w_addr_o    = w_en_o ? WADDR_W'(o_q * INPUT_SIZE + j_q) : '0;
    assign out_valid_o = state_q == OUT;
    assign out_data_o  = out_q;
    assign out_index_o = o_q;
    assign out_last_o  = out_valid_o && o_q == OIW'(OUTPUT_SIZE - 1);
    assign busy_o      = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        j_d     = j_q;
        acc_d   = acc_q;
        out_d   = out_q;
        data_d  = data_q;
        bias_d  = bias_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                data_d  = in_data_i;
                bias_d  = in_bias_i;
                o_d     = '0;
                j_d     = '0;
                acc_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d   = acc_q + prod;
                j_d     = j_q + 1'b1;
                state_d = j_q == JW'(INPUT_SIZE - 1) ? BIAS : MAC;
            end
            BIAS: begin
                out_d   = acc_q + prod + bias_x;
                state_d = OUT;
            end
            default: if (out_ready_i) begin
                state_d = o_q == OIW'(OUTPUT_SIZE - 1) ? IDLE : MAC;
                o_d     = o_q == OIW'(OUTPUT_SIZE - 1) ? o_q : o_q + 1'b1;
                j_d     = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            o_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
            v_q     <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            data_q  <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            j_q     <= j_d;
            idx_q   <= j_q;
            v_q     <= state_q == MAC;
            acc_q   <= acc_d;
            out_q   <= out_d;
            data_q  <= data_d;
            bias_q  <= bias_d;
        end
    end
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: directed and randomized checks of fc_sequencer against a dot-product reference model
module tb_fc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [55:0] in_data = '0;
    logic [39:0] in_bias = '0;
    logic        w_en;
    logic [5:0]  w_addr;
    logic [7:0]  w_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    logic [55:0] cur_d;
    logic [39:0] cur_b;
    logic [7:0]  wmem [35];
    int          sv [7] = '{1, -1, 2, -2, 3, -3, 4};

    fc_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_bias_i(in_bias),
        .w_en_o(w_en), .w_addr_o(w_addr), .w_rdata_i(w_rdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_index_o(out_index), .out_last_o(out_last),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (w_en) w_rdata <= wmem[int'(w_addr)];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_out(input int o);
        int s;
        s = int'($signed(cur_b[o*8 +: 8]));
        for (int j = 0; j < 7; j++)
            s += int'($signed(cur_d[j*8 +: 8])) * int'($signed(wmem[o*7+j]));
        return s[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_all();
        for (int j = 0; j < 7; j++) cur_d[j*8 +: 8] = 8'($urandom);
        for (int o = 0; o < 5; o++) cur_b[o*8 +: 8] = 8'($urandom);
        for (int i = 0; i < 35; i++) wmem[i] = 8'($urandom);
    endtask

    task automatic run_vec(input int stall_o, input bit timing);
        int n, k, cnt;
        logic [15:0] e;
        check("idle_ready", {30'd0, in_ready, busy}, 32'b10);
        in_data = cur_d;
        in_bias = cur_b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        for (int o = 0; o < 5; o++) begin
            k = 0;
            cnt = 0;
            while (!out_valid && cnt < 40) begin
                if (w_en) begin
                    check("w_addr", {26'd0, w_addr}, o * 7 + k);
                    k++;
                end
                @(posedge clk);
                @(negedge clk);
                n++;
                cnt++;
            end
            check("reads", k, 7);
            check("out_valid", {31'd0, out_valid}, 1);
            if (timing && o == 0) check("latency", n, 8);
            e = ref_out(o);
            check("out_data", {16'd0, out_data}, {16'd0, e});
            check("out_meta", {25'd0, out_index, out_last, w_en, in_ready, busy},
                  {25'd0, 3'(o), o == 4, 1'b0, 1'b0, 1'b1});
            if (o == stall_o) begin
                out_ready = 1'b0;
                repeat (20) begin
                    @(posedge clk);
                    @(negedge clk);
                    n++;
                    check("stall", {10'd0, out_valid, w_en, in_ready, out_index, out_data},
                          {10'd0, 1'b1, 1'b0, 1'b0, 3'(o), e});
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (timing) check("total_cycles", n, 45);
        check("done", {29'd0, in_ready, busy, out_valid}, 32'b100);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {2'd0, in_ready, out_valid, out_data, out_index, out_last, w_en, w_addr, busy}, 0);
        rst_n = 1'b1;
        #1;
        check("reset_release", {31'd0, in_ready}, 1);

        for (int j = 0; j < 7; j++) cur_d[j*8 +: 8] = 8'h01;
        cur_b = {5{8'hFD}};
        for (int i = 0; i < 35; i++) wmem[i] = 8'(i / 7 + 1);
        run_vec(-1, 1'b1);

        cur_d = {7{8'h80}};
        cur_b = '0;
        for (int i = 0; i < 35; i++) wmem[i] = 8'h80;
        run_vec(-1, 1'b1);

        for (int j = 0; j < 7; j++) cur_d[j*8 +: 8] = 8'(sv[j]);
        cur_b = {5{8'h05}};
        for (int i = 0; i < 35; i++) wmem[i] = 8'h02;
        run_vec(-1, 1'b0);

        randomize_all();
        run_vec(2, 1'b0);
        randomize_all();
        run_vec(-1, 1'b1);

        begin
            int cnt;
            randomize_all();
            in_data = cur_d;
            in_bias = cur_b;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            cnt = 0;
            while (!(w_en && out_index == 3'd1 && w_addr == 6'd10) && cnt < 100) begin
                @(posedge clk);
                @(negedge clk);
                cnt++;
            end
            check("reach_neuron1", {31'd0, cnt < 100}, 1);
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("midrun_reset", {2'd0, in_ready, out_valid, out_data, out_index, out_last, w_en, w_addr, busy}, 0);
            rst_n = 1'b1;
            #1;
            check("midrun_idle", {30'd0, in_ready, busy}, 32'b10);
        end

        randomize_all();
        run_vec(-1, 1'b1);
        randomize_all();
        run_vec(4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fc_sequencer.md
# fc_sequencer

Time-multiplexed controller for the fully-connected layer. It accepts one input vector and bias vector per handshake. It computes every output neuron with a single shared signed multiplier and accumulator, reading weights one per cycle from an external synchronous weight memory. It emits one 2*BITWIDTH result per neuron over a valid/ready stream. It replaces the fully-parallel multiplier array where area matters more than latency, and produces bit-identical results to it.

## Interface
- BITWIDTH, 8, width of data, weight and bias elements (two's complement)
- INPUT_SIZE, 7, elements per input vector
- OUTPUT_SIZE, 5, output neurons
- WADDR_W, $clog2(INPUT_SIZE*OUTPUT_SIZE), weight address width
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input vector and bias present
- in_ready  out  1  block can accept a vector
- in_data  in  BITWIDTH*INPUT_SIZE  element j at bits [(j+1)*BITWIDTH-1 -: BITWIDTH]
- in_bias  in  BITWIDTH*OUTPUT_SIZE  bias for neuron o at bits [(o+1)*BITWIDTH-1 -: BITWIDTH]
- w_en  out  1  weight memory read enable
- w_addr  out  WADDR_W  weight index o*INPUT_SIZE+j
- w_rdata  in  BITWIDTH  weight data, valid exactly 1 cycle after w_en
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  2*BITWIDTH  neuron result
- out_index  out  $clog2(OUTPUT_SIZE) (min 1)  neuron number o of out_data
- out_last  out  1  out_data is neuron OUTPUT_SIZE-1
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, MAC, BIAS, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, register in_data and in_bias, set o=0, j=0, acc=0, go to MAC.
- MAC: w_en=1, w_addr=o*INPUT_SIZE+j, j++ each cycle. Keep a 1-cycle delayed issue-valid flag and index. When the flag is set: acc += data[idx]*w_rdata, as a signed BITWIDTH x BITWIDTH product giving 2*BITWIDTH bits. After issuing j=INPUT_SIZE-1, go to BIAS.
- BIAS: w_en=0. Add the final product plus sign-extended bias[o] to acc. Register the result into out_data. Go to OUT.
- OUT: out_valid=1, out_index=o, out_last=(o==OUTPUT_SIZE-1). Hold every output stable until out_ready.
  - On handshake with o<OUTPUT_SIZE-1: o++, j=0, acc=0, go to MAC.
  - On handshake with the last neuron: go to IDLE.
- Arithmetic: accumulator is 2*BITWIDTH bits and wraps modulo 2^(2*BITWIDTH). No saturation. Products and bias are sign-extended.
- Input registers are not modified outside IDLE. in_valid while busy is ignored, since in_ready=0.
- w_en is low in IDLE, BIAS and OUT. Weight memory is never read speculatively.

## Timing
- Reset (rst_n=0 at a clock edge), all outputs: in_ready=0 during reset, then 1 in IDLE. out_valid=0, out_data=0, out_index=0, out_last=0, w_en=0, w_addr=0, busy=0. acc, o, j and the delay flag are cleared.
- Reset mid-operation: abort at once, even with out_valid high. The result is dropped and the state is IDLE on the next cycle.
- Accept at cycle T: MAC occupies T+1..T+INPUT_SIZE, BIAS is T+INPUT_SIZE+1, out_valid rises at T+INPUT_SIZE+2 (T+9 at defaults).
- Output handshake at cycle U with o not last: next out_valid at U+INPUT_SIZE+2.
- Whole vector with out_ready tied high: OUTPUT_SIZE*(INPUT_SIZE+2) cycles from accept to the final handshake (45 at defaults). in_ready returns 1 the cycle after the last handshake.
- Back-to-back vectors: in_valid may be accepted in the first IDLE cycle, so there is no extra bubble.
- out_ready held low: stall indefinitely in OUT with no further weight reads.

## Test plan
- Basic: data all 1, w[o][j]=o+1, bias all 0xFD (-3). Required out_data = 4, 11, 18, 25, 32 with out_index 0..4, and out_last only on index 4.
- Wrap: data all 0x80, weights all 0x80, bias 0. Each product is 16384, 7*16384 mod 65536 = 0xC000, so every neuron gives 0xC000.
- Signs: data=[1,-1,2,-2,3,-3,4], weights all 2, bias 5. Required result 13 (0x000D) for every neuron.
- Latency/address check: accept at cycle T. Required w_addr 0..6 on cycles T+1..T+7, out_valid at T+9, and 45 cycles to the final handshake with out_ready high.
- Backpressure: hold out_ready low for 20 cycles on neuron 2. Required: out_data and out_index stable, w_en=0, in_ready=0, and the remaining results still correct afterwards.
- Reset mid-run: assert rst_n=0 for 1 cycle during MAC of neuron 1. Required: all outputs at their reset values, IDLE next cycle, and a following vector computed correctly with no residual accumulator.
